// File: rtl/id_stage.sv
// id_stage: RV32I instruction decode stage.
// Decodes the fetched word, reads the register file combinationally, detects
// load-use hazards against the instruction in execute and registers the
// decoded bundle for the execute stage with one cycle of latency.
module id_stage #(
  parameter bit ILLEGAL_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_if_valid,
  input  logic [31:0] i_if_pc,
  input  logic [31:0] i_if_instr,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_load,
  input  logic [4:0]  i_ex_rd,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output logic        o_hazard,
  output logic        o_id_valid,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_rs1_data,
  output logic [31:0] o_id_rs2_data,
  output logic [31:0] o_id_imm,
  output logic [4:0]  o_id_rd,
  output logic        o_id_rd_we,
  output logic [3:0]  o_id_class,
  output logic [3:0]  o_id_alu_op,
  output logic [2:0]  o_id_funct3,
  output logic        o_id_illegal
);

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Instruction classes
  typedef enum logic [3:0] {
    CLS_OP      = 4'd0,
    CLS_OPIMM   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd15
  } id_class_e;

  // ALU operations
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // Registered decode bundle handed to execute
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rd_we;
    logic [3:0]  cls;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    logic        illegal;
  } id_reg_t;

  // Register-register and register-immediate ALU mapping; SUB only exists for OP
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic alt,
                                                 input logic is_op);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_op && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [3:0]  dec_class;
  logic [3:0]  dec_alu;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  logic        dec_writes;
  logic        rs1_used;
  logic        rs2_used;

  id_reg_t id_d, id_q;

  assign opcode     = i_if_instr[6:0];
  assign funct3     = i_if_instr[14:12];
  assign funct7     = i_if_instr[31:25];
  assign rd         = i_if_instr[11:7];
  assign o_rs1_addr = i_if_instr[19:15];
  assign o_rs2_addr = i_if_instr[24:20];

  assign imm_i = {{20{i_if_instr[31]}}, i_if_instr[31:20]};
  assign imm_s = {{20{i_if_instr[31]}}, i_if_instr[31:25], i_if_instr[11:7]};
  assign imm_b = {{19{i_if_instr[31]}}, i_if_instr[31], i_if_instr[7],
                  i_if_instr[30:25], i_if_instr[11:8], 1'b0};
  assign imm_u = {i_if_instr[31:12], 12'b0};
  assign imm_j = {{11{i_if_instr[31]}}, i_if_instr[31], i_if_instr[19:12],
                  i_if_instr[20], i_if_instr[30:21], 1'b0};

  // Instruction decode: class, immediate, ALU op, legality and operand usage
  always_comb begin
    dec_class   = CLS_ILLEGAL;
    dec_alu     = ALU_ADD;
    dec_imm     = 32'd0;
    dec_illegal = 1'b1;
    dec_writes  = 1'b0;
    rs1_used    = 1'b1;
    rs2_used    = 1'b0;
    case (opcode)
      OPC_OP: begin
        rs2_used = 1'b1;
        if ((funct7 == 7'b0000000) ||
            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          dec_class   = CLS_OP;
          dec_alu     = alu_from_funct3(funct3, i_if_instr[30], 1'b1);
          dec_illegal = 1'b0;
          dec_writes  = 1'b1;
        end
      end
      OPC_OPIMM: begin
        if (!((funct3 == 3'b001) && (funct7 != 7'b0000000)) &&
            !((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000))) begin
          dec_class   = CLS_OPIMM;
          dec_alu     = alu_from_funct3(funct3, i_if_instr[30], 1'b0);
          dec_imm     = imm_i;
          dec_illegal = 1'b0;
          dec_writes  = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec_class   = CLS_LOAD;
        dec_imm     = imm_i;
        dec_illegal = 1'b0;
        dec_writes  = 1'b1;
      end
      OPC_STORE: begin
        rs2_used    = 1'b1;
        dec_class   = CLS_STORE;
        dec_imm     = imm_s;
        dec_illegal = 1'b0;
      end
      OPC_BRANCH: begin
        rs2_used    = 1'b1;
        dec_class   = CLS_BRANCH;
        dec_imm     = imm_b;
        dec_illegal = 1'b0;
        if (funct3[2:1] == 2'b11) dec_alu = ALU_SLTU;
        else if (funct3[2])       dec_alu = ALU_SLT;
        else                      dec_alu = ALU_SUB;
      end
      OPC_JAL: begin
        rs1_used    = 1'b0;
        dec_class   = CLS_JAL;
        dec_imm     = imm_j;
        dec_illegal = 1'b0;
        dec_writes  = 1'b1;
      end
      OPC_JALR: begin
        dec_class   = CLS_JALR;
        dec_imm     = imm_i;
        dec_illegal = 1'b0;
        dec_writes  = 1'b1;
      end
      OPC_LUI: begin
        rs1_used    = 1'b0;
        dec_class   = CLS_LUI;
        dec_imm     = imm_u;
        dec_illegal = 1'b0;
        dec_writes  = 1'b1;
      end
      OPC_AUIPC: begin
        rs1_used    = 1'b0;
        dec_class   = CLS_AUIPC;
        dec_imm     = imm_u;
        dec_illegal = 1'b0;
        dec_writes  = 1'b1;
      end
      OPC_FENCE: begin
        dec_class   = CLS_FENCE;
        dec_imm     = imm_i;
        dec_illegal = 1'b0;
      end
      OPC_SYSTEM: begin
        dec_class   = CLS_SYSTEM;
        dec_imm     = imm_i;
        dec_illegal = 1'b0;
        dec_writes  = (funct3 != 3'b000);
      end
      default: begin
        // With ILLEGAL_ZERO cleared, an all-zero word is accepted as a nop
        if (!ILLEGAL_ZERO && (i_if_instr == 32'd0)) begin
          rs1_used    = 1'b0;
          dec_class   = CLS_OPIMM;
          dec_illegal = 1'b0;
        end
      end
    endcase
  end

  // Load-use hazard against the load currently in execute
  assign o_hazard = i_if_valid && i_ex_valid && i_ex_is_load && (i_ex_rd != 5'd0) &&
                    ((rs1_used && (i_ex_rd == o_rs1_addr)) ||
                     (rs2_used && (i_ex_rd == o_rs2_addr)));

  // Next output bundle: flush, then stall hold, then hazard bubble, then capture
  always_comb begin
    id_d = id_q;
    if (i_flush) begin
      id_d = '0;
    end else if (i_stall) begin
      id_d = id_q;
    end else if (o_hazard) begin
      id_d = '0;
    end else begin
      id_d.valid    = i_if_valid;
      id_d.pc       = i_if_pc;
      id_d.instr    = i_if_instr;
      id_d.rs1_data = i_rs1_data;
      id_d.rs2_data = i_rs2_data;
      id_d.imm      = dec_imm;
      id_d.rd       = rd;
      id_d.rd_we    = dec_writes && (rd != 5'd0);
      id_d.cls      = dec_class;
      id_d.alu_op   = dec_alu;
      id_d.funct3   = funct3;
      id_d.illegal  = dec_illegal;
    end
  end

  // Output register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) id_q <= '0;
    else        id_q <= id_d;
  end

  assign o_id_valid    = id_q.valid;
  assign o_id_pc       = id_q.pc;
  assign o_id_instr    = id_q.instr;
  assign o_id_rs1_data = id_q.rs1_data;
  assign o_id_rs2_data = id_q.rs2_data;
  assign o_id_imm      = id_q.imm;
  assign o_id_rd       = id_q.rd;
  assign o_id_rd_we    = id_q.rd_we;
  assign o_id_class    = id_q.cls;
  assign o_id_alu_op   = id_q.alu_op;
  assign o_id_funct3   = id_q.funct3;
  assign o_id_illegal  = id_q.illegal;

endmodule
